snake_game_ctrl: RTL
====================

# snake_game_ctrl

Game sequencer for the VGA snake game. It turns per-pixel collision flags from the renderer into once-per-frame decisions: move tick, grow, apple respawn, game over, win. It owns the latched snake direction and snake length that the position shift-register and body-enable logic consume. It sits between the keyboard decoder, the VGA timing generator and the snake/apple datapath, all on the 25 MHz VGA clock.

## Interface
- TICK_FRAMES, 6: frames per snake move (≥1).
- MAX_LEN, 15: body segments; reaching it wins.
- LEN_W, 5: width of `length` (must hold MAX_LEN).
- clk  in  1  VGA pixel clock; sole clock.
- rst  in  1  asynchronous, active-low reset.
- frame_end  in  1  one-cycle pulse after the last visible pixel of a frame.
- dir_req  in  5  keyboard direction, one-hot: 00010 up, 00100 left, 01000 down, 10000 right; any other value is ignored.
- start  in  1  one-cycle pulse (Enter key).
- hit_apple  in  1  head pixel overlaps apple pixel (this cycle).
- hit_body  in  1  head pixel overlaps an enabled body segment.
- hit_border  in  1  head pixel overlaps border.
- apple_bad  in  1  apple pixel overlaps body or border.
- move  out  1  one-cycle pulse: advance head and shift body.
- dir  out  5  latched direction, one-hot as dir_req.
- grow  out  1  one-cycle pulse: apple eaten.
- respawn  out  1  one-cycle pulse: reload apple coordinates.
- length  out  LEN_W  enabled body segments.
- state  out  3  0 IDLE, 1 PLAY, 2 OVER, 3 WIN, 4 PAUSE.
- game_over  out  1  state==OVER.
- win_game  out  1  state==WIN.

## Operation
- Reset values: state IDLE, dir 10000, pending dir 10000, length 0, tick counter 0, sticky flags 0, all pulses 0, game_over 0, win_game 0.
- Sticky flags: in PLAY, each of hit_apple, hit_body, hit_border and apple_bad ORs into its own sticky bit every cycle. All sticky bits clear on the cycle frame_end is seen. In any other state the sticky bits are held at 0.
- Direction: a valid dir_req loads the pending register at any time, with one exception. If length>0, a request opposite to the current dir (up/down, left/right) is dropped. dir takes the pending value on the same edge that move is asserted.
- Transitions:
  - IDLE --start--> PLAY. Also clears length and the tick counter and pulses respawn.
  - OVER or WIN --start--> IDLE.
- Resolution at frame_end in PLAY, priority order:
  1. sticky hit_body or hit_border → OVER. No move, no grow.
  2. sticky hit_apple → grow and respawn. length+1, saturating at MAX_LEN. If the new length == MAX_LEN → WIN.
  3. sticky apple_bad → respawn only.
- Tick: on every PLAY frame_end that does not go to OVER, the counter increments. When it equals TICK_FRAMES-1 it wraps to 0 and move pulses instead. move and grow may pulse together; the datapath shifts first and then enables the new segment.
- The frame_end that enters WIN still issues its move if one is due.
- start with no matching transition is ignored.

## Timing
- All pulses (move, grow, respawn) assert exactly one cycle after the frame_end cycle and last one cycle.
- state changes on that same edge.
- game_over and win_game are registered decodes of the next state. They change together with state.
- start and frame_end in the same cycle while in IDLE: start wins. The frame is not resolved.
- A collision flag asserted in the frame_end cycle itself counts toward the current frame.
- Reset asserted mid-frame: all outputs drop to their reset values immediately (asynchronous). Release is synchronous to clk. The first frame_end after release is handled from IDLE.
- length arithmetic is LEN_W bits and never wraps.

## Configuration
- SNAKE_PAUSE_EN defined:
  - start in PLAY → PAUSE, and start in PAUSE → PLAY.
  - In PAUSE the sticky bits are held at 0, the tick counter freezes, dir_req is ignored, and no pulses are issued.
- SNAKE_PAUSE_EN undefined:
  - state value 4 is unreachable.
  - start in PLAY is ignored.

## Test plan
- Reset, then start → state=1 and respawn pulses once. With TICK_FRAMES=6 and 12 clean frame_end pulses, move pulses on the 6th and 12th only.
- In PLAY, assert hit_apple for 3 cycles mid-frame, then frame_end → grow=1 and respawn=1 one cycle later, length 0→1.
- length=3, dir=right, dir_req=left → dir stays right at the next move. dir_req=up → dir=up at the next move.
- hit_border and hit_apple in the same frame → state=2, game_over=1, no grow, length unchanged. A later start → state=0.
- length=14 and an apple hit → length=15, state=3, win_game=1. Further frame_end pulses give no pulses.
- SNAKE_PAUSE_EN defined: start in PLAY → state=4. 10 frame_end pulses with hit_body → no pulses, no OVER. start → state=1 with the tick counter preserved.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Frame-rate sequencer for the VGA snake game: folds per-pixel collision flags into per-frame
// move/grow/respawn decisions and owns direction and length. SNAKE_PAUSE_EN adds a PAUSE state.
module snake_game_ctrl #(
    parameter int TICK_FRAMES = 6,
    parameter int MAX_LEN     = 15,
    parameter int LEN_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_end,
    input  logic [4:0]       dir_req,
    input  logic             start,
    input  logic             hit_apple,
    input  logic             hit_body,
    input  logic             hit_border,
    input  logic             apple_bad,
    output logic             move,
    output logic [4:0]       dir,
    output logic             grow,
    output logic             respawn,
    output logic [LEN_W-1:0] length,
    output logic [2:0]       state,
    output logic             game_over,
    output logic             win_game
);

    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    localparam int CNT_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_FRAMES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_OVER  = 3'd2,
        S_WIN   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] tick_q, tick_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [4:0]       dir_q, dir_n;
    logic [4:0]       pend_q, pend_n;
    logic [3:0]       sticky_q, sticky_n;   // {apple_bad, hit_border, hit_body, hit_apple}
    logic [3:0]       flags_now;
    logic             move_n, grow_n, respawn_n;
    logic             dir_ok;
    logic             pause_req;
    logic             paused;

`ifdef SNAKE_PAUSE_EN
    assign pause_req = start;
    assign paused    = (state_q == S_PAUSE);
`else
    assign pause_req = 1'b0;
    assign paused    = 1'b0;
`endif

    function automatic logic dir_valid(input logic [4:0] d);
        return (d == DIR_UP) || (d == DIR_LEFT) || (d == DIR_DOWN) || (d == DIR_RIGHT);
    endfunction

    function automatic logic dir_opposite(input logic [4:0] a, input logic [4:0] b);
        return ((a == DIR_UP)   && (b == DIR_DOWN))  || ((a == DIR_DOWN)  && (b == DIR_UP)) ||
               ((a == DIR_LEFT) && (b == DIR_RIGHT)) || ((a == DIR_RIGHT) && (b == DIR_LEFT));
    endfunction

    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
        return (l >= LEN_MAX) ? LEN_MAX : l + LEN_W'(1);
    endfunction

    // A flag raised in the frame_end cycle itself still belongs to the closing frame.
    assign flags_now = sticky_q | {apple_bad, hit_border, hit_body, hit_apple};

    // Reversing into the body is only harmless while there is no body.
    assign dir_ok = dir_valid(dir_req) && !paused &&
                    !((len_q != '0) && dir_opposite(dir_req, dir_q));

    always_comb begin
        state_n   = state_q;
        tick_n    = tick_q;
        len_n     = len_q;
        dir_n     = dir_q;
        pend_n    = pend_q;
        sticky_n  = '0;
        move_n    = 1'b0;
        grow_n    = 1'b0;
        respawn_n = 1'b0;

        if (dir_ok) begin
            pend_n = dir_req;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_PLAY;
                    len_n     = '0;
                    tick_n    = '0;
                    respawn_n = 1'b1;
                end
            end
            S_PLAY: begin
                sticky_n = flags_now;
                if (pause_req) begin
                    state_n  = S_PAUSE;
                    sticky_n = '0;
                end else if (frame_end) begin
                    sticky_n = '0;
                    if (flags_now[1] || flags_now[2]) begin
                        state_n = S_OVER;
                    end else begin
                        if (flags_now[0]) begin
                            grow_n    = 1'b1;
                            respawn_n = 1'b1;
                            len_n     = len_inc(len_q);
                            if (len_n == LEN_MAX) begin
                                state_n = S_WIN;
                            end
                        end else if (flags_now[3]) begin
                            respawn_n = 1'b1;
                        end
                        // The winning frame still moves if its tick is due.
                        if (tick_q == TICK_LAST) begin
                            tick_n = '0;
                            move_n = 1'b1;
                            dir_n  = pend_q;
                        end else begin
                            tick_n = tick_q + CNT_W'(1);
                        end
                    end
                end
            end
            S_OVER, S_WIN: begin
                if (start) begin
                    state_n = S_IDLE;
                end
            end
            S_PAUSE: begin
                if (pause_req) begin
                    state_n = S_PLAY;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            len_q     <= '0;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            sticky_q  <= '0;
            move      <= 1'b0;
            grow      <= 1'b0;
            respawn   <= 1'b0;
            game_over <= 1'b0;
            win_game  <= 1'b0;
        end else begin
            state_q   <= state_n;
            tick_q    <= tick_n;
            len_q     <= len_n;
            dir_q     <= dir_n;
            pend_q    <= pend_n;
            sticky_q  <= sticky_n;
            move      <= move_n;
            grow      <= grow_n;
            respawn   <= respawn_n;
            game_over <= (state_n == S_OVER);
            win_game  <= (state_n == S_WIN);
        end
    end

    assign state  = state_q;
    assign length = len_q;
    assign dir    = dir_q;

endmodule
